// File: rtl/cube_data_reader_if.sv
// Handshake bundle between cube_data_reader and its host/storage side.
// out_par exists only when CUBE_READER_PARITY_EN is defined.
interface cube_data_reader_if #(parameter int DATA_LEN = 8);
  localparam int CW = 384 * DATA_LEN;

  logic          start;
  logic [CW-1:0] cube;
  logic          out_ready;
  logic          out_valid;
  logic [127:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef CUBE_READER_PARITY_EN
  logic [3:0]    out_par;

  modport master (
    input  start, cube, out_ready,
    output out_valid, out_data, out_last, busy, done, out_par
  );
  modport slave (
    output start, cube, out_ready,
    input  out_valid, out_data, out_last, busy, done, out_par
  );
`else
  modport master (
    input  start, cube, out_ready,
    output out_valid, out_data, out_last, busy, done
  );
  modport slave (
    output start, cube, out_ready,
    input  out_valid, out_data, out_last, busy, done
  );
`endif
endinterface

// File: rtl/cube_data_reader.sv
// Snapshots a parallel cube on start and streams it out LSB-first as 128-bit beats.
// Optional per-word even parity on out_par when CUBE_READER_PARITY_EN is defined.
//   state | meaning
//   IDLE  | waiting for start, no beat on the bus
//   SEND  | streaming beats k = 0 .. NB-1 from the snapshot
module cube_data_reader #(
  parameter int DATA_LEN = 8
) (
  input logic               clk,
  input logic               rst,
  cube_data_reader_if.master bus
);
  localparam int NB    = 3 * DATA_LEN;
  localparam int CNT_W = $clog2(NB);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nxt;
  logic [NB-1:0][127:0]   snapshot;
  logic [CNT_W-1:0]       k, k_inc;
  logic                   accept, xfer, xfer_last;
  logic [127:0]           beat_nxt;
  logic                   out_valid_q, out_last_q, busy_q, done_q;
  logic [127:0]           out_data_q;

  assign k_inc = k + CNT_W'(1);
  // First beat comes straight from the cube input since the snapshot loads on the same edge
  assign beat_nxt = accept ? bus.cube[127:0] : snapshot[k_inc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    xfer      = 1'b0;
    xfer_last = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_valid_q && bus.out_ready) begin
          xfer = 1'b1;
          if (k == K_LAST) begin
            xfer_last = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot    <= '0;
      k           <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        snapshot    <= bus.cube;
        k           <= '0;
        out_valid_q <= 1'b1;
        out_data_q  <= beat_nxt;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b1;
      end else if (xfer_last) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
      end else if (xfer) begin
        k          <= k_inc;
        out_data_q <= beat_nxt;
        out_last_q <= (k_inc == K_LAST);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef CUBE_READER_PARITY_EN
  logic [3:0] out_par_q;

  function automatic logic [3:0] word_parity(input logic [127:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[32*i +: 32];
    return p;
  endfunction

  // Loaded on exactly the edges that load out_data so the two never skew
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          out_par_q <= '0;
    else if (accept || (xfer && !xfer_last)) out_par_q <= word_parity(beat_nxt);
  end

  assign bus.out_par = out_par_q;
`endif

endmodule

// File: tb/tb_cube_data_reader.sv
// Directed bench for cube_data_reader: DATA_LEN=1 instance for handshake corner cases,
// DATA_LEN=8 instance for a long randomized-ready stream. Define CUBE_READER_PARITY_EN to check out_par.
module tb_cube_data_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cube_data_reader_if #(.DATA_LEN(1)) b1 ();
  cube_data_reader_if #(.DATA_LEN(8)) b8 ();

  cube_data_reader #(.DATA_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  cube_data_reader #(.DATA_LEN(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  localparam logic [383:0] CUBE_A = {128'h2, 128'h1, 128'h82a54907b1630900184e800098f};
  localparam logic [383:0] CUBE_B = {128'hcafef00d_0badbeef_13579bdf_2468ace0,
                                     128'h11112222_33334444_55556666_77778888,
                                     128'hdeadbeef_01234567_89abcdef_fedcba98};

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] par4(input logic [127:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[32*i +: 32];
    return p;
  endfunction

  // Called at the negedge after start was accepted; returns at the negedge where done should be high.
  task automatic drain1(input logic [383:0] ec, input int stall_beat, input int stall_len,
                        input bit disturb, input logic [383:0] alt);
    int idx = 0;
    int stalled = 0;
    int cyc = 0;
    logic [127:0] eb;
    while (idx < 3 && cyc < 40) begin
      eb = ec[idx*128 +: 128];
      b1.start = 1'b0;
      if (disturb && idx == 1) begin
        b1.cube  = alt;
        b1.start = 1'b1;
      end
      if (idx == stall_beat && stalled < stall_len) begin
        b1.out_ready = 1'b0;
        stalled++;
        check("stall_valid", 128'(b1.out_valid), 128'(1'b1));
        check("stall_data", b1.out_data, eb);
        check("stall_last", 128'(b1.out_last), 128'(idx == 2));
      end else begin
        b1.out_ready = 1'b1;
        check("beat_valid", 128'(b1.out_valid), 128'(1'b1));
        check("beat_data", b1.out_data, eb);
        check("beat_last", 128'(b1.out_last), 128'(idx == 2));
        check("beat_busy", 128'(b1.busy), 128'(1'b1));
`ifdef CUBE_READER_PARITY_EN
        check("beat_par", 128'(b1.out_par), 128'(par4(eb)));
`endif
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    b1.start = 1'b0;
    if (idx < 3) check("drain1_timeout", 128'(idx), 128'(3));
    check("done_pulse", 128'(b1.done), 128'(1'b1));
    check("done_busy", 128'(b1.busy), 128'(1'b0));
    check("done_valid", 128'(b1.out_valid), 128'(1'b0));
  endtask

  task automatic after_done1();
    @(negedge clk);
    check("done_clear", 128'(b1.done), 128'(1'b0));
    check("idle_valid", 128'(b1.out_valid), 128'(1'b0));
  endtask

  task automatic start1(input logic [383:0] c);
    b1.cube      = c;
    b1.start     = 1'b1;
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.start     = 1'b0;
  endtask

  initial begin
    logic [3071:0] rc;
    logic [127:0]  eb;
    int idx, cyc, n_last;

    rst = 1'b1;
    b1.start = 1'b0; b1.cube = '0; b1.out_ready = 1'b0;
    b8.start = 1'b0; b8.cube = '0; b8.out_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 128'(b1.out_valid), 128'(1'b0));
    check("rst_data", b1.out_data, 128'h0);
    check("rst_last", 128'(b1.out_last), 128'(1'b0));
    check("rst_busy", 128'(b1.busy), 128'(1'b0));
    check("rst_done", 128'(b1.done), 128'(1'b0));
    check("rst8_valid", 128'(b8.out_valid), 128'(1'b0));
    check("rst8_data", b8.out_data, 128'h0);
`ifdef CUBE_READER_PARITY_EN
    check("rst_par", 128'(b1.out_par), 128'h0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // basic stream under continuous ready
    start1(CUBE_A);
`ifdef CUBE_READER_PARITY_EN
    check("par_beat0", 128'(b1.out_par), 128'(4'b0011));
`endif
    drain1(CUBE_A, -1, 0, 1'b0, '0);
    after_done1();

    // backpressure on beat 1 for four cycles
    start1(CUBE_A);
    drain1(CUBE_A, 1, 4, 1'b0, '0);
    after_done1();

    // cube change plus start during SEND is ignored; start on the done cycle is taken
    start1(CUBE_A);
    drain1(CUBE_A, -1, 0, 1'b1, CUBE_B);
    b1.start = 1'b1;
    @(negedge clk);
    drain1(CUBE_B, -1, 0, 1'b0, '0);
    after_done1();

    // async reset mid-stream abandons the stream
    start1(CUBE_B);
    @(negedge clk);
    check("pre_rst_beat1", b1.out_data, CUBE_B[255:128]);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(b1.out_valid), 128'(1'b0));
    check("mid_rst_data", b1.out_data, 128'h0);
    check("mid_rst_last", 128'(b1.out_last), 128'(1'b0));
    check("mid_rst_busy", 128'(b1.busy), 128'(1'b0));
    check("mid_rst_done", 128'(b1.done), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", 128'(b1.done), 128'(1'b0));
    check("post_rst_valid", 128'(b1.out_valid), 128'(1'b0));
    start1(CUBE_A);
    drain1(CUBE_A, -1, 0, 1'b0, '0);
    after_done1();

    // DATA_LEN=8, random cube and random ready
    for (int i = 0; i < 96; i++) rc[32*i +: 32] = $urandom;
    b8.cube  = rc;
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    b8.cube  = ~rc;
    idx = 0; cyc = 0; n_last = 0;
    while (idx < 24 && cyc < 400) begin
      b8.out_ready = 1'($urandom_range(0, 1));
      if (b8.out_valid && b8.out_ready) begin
        eb = rc[idx*128 +: 128];
        check("l8_data", b8.out_data, eb);
        check("l8_last", 128'(b8.out_last), 128'(idx == 23));
`ifdef CUBE_READER_PARITY_EN
        check("l8_par", 128'(b8.out_par), 128'(par4(eb)));
`endif
        if (b8.out_last) n_last++;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < 24) check("l8_timeout", 128'(idx), 128'(24));
    check("l8_last_count", 128'(n_last), 128'(1));
    check("l8_done", 128'(b8.done), 128'(1'b1));
    check("l8_idle_valid", 128'(b8.out_valid), 128'(1'b0));
    @(negedge clk);
    check("l8_done_clear", 128'(b8.done), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
